// File: rtl/port_dispatch_pkg.sv
// port_dispatch_pkg: shared types and constants for the port dispatcher.
// Holds the FSM state encoding and the error codes reported on err_code.
package port_dispatch_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_NONE    = 2'b00;
   localparam err_code_t ERR_INVALID = 2'b01;
   localparam err_code_t ERR_TIMEOUT = 2'b10;
   localparam err_code_t ERR_COLLIDE = 2'b11;

endpackage

// File: rtl/port_dispatch_if.sv
// port_dispatch_if: processor I/O access and peripheral channel bundle.
// The master side issues strobes and acknowledges; the slave side (the
// dispatcher) drives activation, status and error reporting.
interface port_dispatch_if
   import port_dispatch_pkg::*;
#(
   parameter int ID_W  = 8,
   parameter int LOC_W = 4,
   parameter int N_CH  = 4
);

   logic [ID_W-1:0]  id_port;
   logic             wr_strobe;
   logic             rd_strobe;
   logic [N_CH-1:0]  ch_ack;
   logic [N_CH-1:0]  act;
   logic             act_wr;
   logic [LOC_W-1:0] dir;
   logic             busy;
   logic             done;
   logic             err;
   err_code_t        err_code;

   modport master (
      output id_port, wr_strobe, rd_strobe, ch_ack,
      input  act, act_wr, dir, busy, done, err, err_code
   );

   modport slave (
      input  id_port, wr_strobe, rd_strobe, ch_ack,
      output act, act_wr, dir, busy, done, err, err_code
   );

endinterface

// File: rtl/port_dispatch_timeout_ctr.sv
// dispatch_timeout_ctr: cycle counter bounding how long a channel may stay
// active without acknowledging. expired is high in the last allowed cycle.
// Only instantiated when PORT_DISPATCH_TIMEOUT_EN is defined.
module dispatch_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] count;

   // Count waiting cycles; clear has priority so each transaction starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/port_dispatch.sv
// port_dispatch: registered port-ID decoder with per-channel ack handshake.
// Maps id_port onto one of N_CH channels, holds the one-hot activation and
// local address until the channel acknowledges, and reports busy/done/err.
// Optional feature: define PORT_DISPATCH_TIMEOUT_EN to abort transactions
// that stay unacknowledged for TIMEOUT cycles (err_code 10).
module port_dispatch
   import port_dispatch_pkg::*;
#(
   parameter int ID_W    = 8,
   parameter int LOC_W   = 4,
   parameter int N_CH    = 4,
   parameter int TIMEOUT = 16
) (
   input logic           clk,
   input logic           rst_n,
   port_dispatch_if.slave bus
);

   localparam int CH_W = ID_W - LOC_W;

   // Reject configurations where channels cannot all be addressed.
   if (N_CH > (1 << CH_W)) begin : g_bad_nch
      $error("port_dispatch: N_CH exceeds addressable channel count");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("port_dispatch: TIMEOUT must be at least 2");
   end

   state_t          state;
   logic [CH_W-1:0] ch_idx;
   logic            ch_valid;
   logic [N_CH-1:0] ch_onehot;
   logic            any_strobe;
   logic            both_strobe;
   logic            ack_hit;
   logic            timed_out;

   assign ch_idx      = bus.id_port[ID_W-1:LOC_W];
   assign ch_valid    = ({1'b0, ch_idx} < (CH_W + 1)'(N_CH));
   assign any_strobe  = bus.wr_strobe | bus.rd_strobe;
   assign both_strobe = bus.wr_strobe & bus.rd_strobe;
   // act is one-hot on the latched channel, so masking acks with it keeps
   // only the owning channel's acknowledge.
   assign ack_hit     = |(bus.ch_ack & bus.act);

   // Decode the requested channel index into a one-hot activation vector.
   always_comb begin
      ch_onehot = '0;
      for (int i = 0; i < N_CH; i++) begin
         ch_onehot[i] = ({1'b0, ch_idx} == (CH_W + 1)'(i));
      end
   end

`ifdef PORT_DISPATCH_TIMEOUT_EN
   logic to_clear;
   logic to_enable;

   assign to_clear  = (state == IDLE);
   assign to_enable = (state == WAIT) && !ack_hit;

   dispatch_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (to_clear),
      .enable (to_enable),
      .expired(timed_out)
   );
`else
   assign timed_out = 1'b0;
`endif

   // Transaction FSM: accepts strobes in IDLE, holds the channel in WAIT
   // until ack (or timeout), and produces the registered status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bus.act      <= '0;
         bus.act_wr   <= 1'b0;
         bus.dir      <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
         bus.err_code <= ERR_NONE;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            IDLE: begin
               if (both_strobe) begin
                  bus.err      <= 1'b1;
                  bus.err_code <= ERR_COLLIDE;
               end else if (any_strobe) begin
                  if (ch_valid) begin
                     bus.act    <= ch_onehot;
                     bus.act_wr <= bus.wr_strobe;
                     bus.dir    <= bus.id_port[LOC_W-1:0];
                     bus.busy   <= 1'b1;
                     state      <= WAIT;
                  end else begin
                     bus.err      <= 1'b1;
                     bus.err_code <= ERR_INVALID;
                  end
               end
            end
            WAIT: begin
               if (any_strobe) begin
                  bus.err      <= 1'b1;
                  bus.err_code <= ERR_COLLIDE;
               end
               if (ack_hit) begin
                  bus.act  <= '0;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= IDLE;
               end else if (timed_out) begin
                  bus.act      <= '0;
                  bus.busy     <= 1'b0;
                  bus.err      <= 1'b1;
                  bus.err_code <= ERR_TIMEOUT;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/port_dispatch.md
# port_dispatch

Parametrised, registered successor to the combinational port-ID decoder. Accepts a processor I/O access (port ID plus read/write strobe), maps the ID onto one of N_CH peripheral channels (RTC, VGA, keyboard, sound, …), and holds that channel's activation plus local address until the peripheral acknowledges. It sits between the soft-core I/O bus and the peripheral controllers, and adds the following over the old decoder:
- per-channel ack handshake;
- busy and done status;
- error reporting;
- an optional timeout.

## Interface
- ID_W, 8, width of the port ID
- LOC_W, 4, local address width; each channel owns 2^LOC_W consecutive IDs
- N_CH, 4, number of channels; must satisfy N_CH ≤ 2^(ID_W−LOC_W)
- TIMEOUT, 16, maximum cycles `act` is held without ack (≥2; used only with the macro)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_port  in  ID_W  port ID, sampled with a strobe
- wr_strobe  in  1  write access request, 1-cycle
- rd_strobe  in  1  read access request, 1-cycle
- ch_ack  in  N_CH  per-channel completion acknowledge
- act  out  N_CH  one-hot channel activation, level, held during the transaction
- act_wr  out  1  1 = write transaction, 0 = read; valid while `act` ≠ 0
- dir  out  LOC_W  local address, id_port[LOC_W−1:0]
- busy  out  1  transaction in progress
- done  out  1  1-cycle pulse on acknowledged completion
- err  out  1  1-cycle error pulse
- err_code  out  2  01 invalid ID, 10 timeout, 11 collision/overrun; holds its last value between pulses

## Operation
- Channel index: ch = id_port[ID_W−1:LOC_W]. ch ≥ N_CH means the ID is invalid.
- FSM states: IDLE, WAIT.
- IDLE, exactly one strobe, valid ch:
  - latch ch, dir and act_wr (= wr_strobe);
  - set act[ch] and busy;
  - go to WAIT.
- IDLE, exactly one strobe, invalid ch: err pulse with code 01. Stay in IDLE; act, dir and act_wr are unchanged.
- IDLE, wr_strobe and rd_strobe together: err pulse with code 11, no transaction.
- WAIT:
  - only ch_ack[ch] is observed; acks on other channels are ignored;
  - on ch_ack[ch]: clear act and busy, pulse done, go to IDLE.
- WAIT, any strobe: err pulse with code 11. The strobe is dropped and the current transaction continues. If ack and overrun occur in the same cycle, done and err pulse together.
- Timeout (with macro only): a counter clears on entry to WAIT and increments each WAIT cycle without ack. When the counter equals TIMEOUT−1 and no ack is present: clear act and busy, err pulse with code 10, no done, go to IDLE.
- Ack on the final timeout cycle: the ack wins and the transaction completes normally.
- Reset values:
  - state IDLE;
  - act = 0, act_wr = 0, dir = 0;
  - busy, done, err = 0;
  - err_code = 00;
  - counter = 0.
- Reset mid-transaction aborts immediately; no done or err is produced.

## Timing
- All outputs are registered.
- A strobe sampled at edge T makes act, busy, dir and act_wr visible after edge T (latency 1).
- ch_ack high in the cycle act is first visible is accepted: act is high for exactly 1 cycle.
- ack sampled at edge K: act falls and done rises after edge K; done lasts exactly 1 cycle.
- A new strobe is accepted in the cycle done is high, which gives back-to-back throughput of 1 transaction per 2 cycles.
- Timeout: act is high for exactly TIMEOUT cycles.
- err is asserted 1 cycle after the offending strobe, or after the timeout edge.

## Configuration
- PORT_DISPATCH_TIMEOUT_EN defined:
  - the timeout counter, of width clog2(TIMEOUT), is present;
  - code 10 can occur.
- PORT_DISPATCH_TIMEOUT_EN undefined:
  - no counter; WAIT persists until ack or reset;
  - code 10 never occurs;
  - the TIMEOUT parameter is ignored.

## Structure
- Package port_dispatch_pkg holds:
  - the state enum (IDLE, WAIT);
  - err codes ERR_INVALID = 2'b01, ERR_TIMEOUT = 2'b10, ERR_COLLIDE = 2'b11.
- Sub-module dispatch_timeout_ctr (clear, enable, expired), instantiated only under the macro.
- The top level holds the FSM, address latch and decode.

## Test plan
All scenarios use default parameters and the macro defined unless stated otherwise.
- Reset: after rst_n is released → all outputs 0, err_code 00.
- wr_strobe with id_port = 0x25, ack on ch 2 three cycles later:
  - act = 4'b0100, dir = 5, act_wr = 1, busy = 1 for 3 cycles;
  - then a done pulse and act = 0.
- rd_strobe with id_port = 0x73 (ch 7 ≥ 4) → err pulse with code 01; act stays 0, busy stays 0.
- rd_strobe with id_port = 0x10, no ack:
  - act = 4'b0010 for exactly 16 cycles;
  - then an err pulse with code 10 and no done.
  - With the macro undefined: act is still high after 100 cycles.
- During WAIT on ch 0: ack on ch 3 is ignored; a wr_strobe gives an err pulse with code 11 while act stays 4'b0001; the later ack on ch 0 gives done.
- wr_strobe and rd_strobe together → code 11, no act. Then rst_n is asserted mid-WAIT → act = 0 immediately, with no done or err.
